// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed service latency, valid/ready on both channels.
// Define DMEM_ERR_EN to flag misaligned and out-of-range accesses through resp_err.
module dmem_responder #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           up;
  logic           accept;
  logic           fault;
  logic [AW-1:0]  idx;
  logic [N-1:0]   mem [DEPTH];

  assign idx = req_addr[AW+2:3];

`ifdef DMEM_ERR_EN
  assign fault = (req_addr[2:0] != 3'b000) || (req_addr >= N'(DEPTH * 8));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[N-1:AW+3], req_addr[2:0]};
  assign fault = 1'b0;
`endif

  // Keeps req_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) up <= 1'b0;
    else        up <= 1'b1;
  end

  assign req_ready  = up && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response payload is captured at the accept edge so later read data reflects pre-store ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= (req_write || fault) ? '0 : mem[idx];
      resp_err   <= fault;
    end else if (resp_valid && resp_ready) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

  // Stores commit at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !fault) mem[idx] <= req_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table + scoreboard, with corner-case sequences
// and two extra instances that check LATENCY=1 and LATENCY=4 timing.
module tb_dmem_responder;

  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        x_valid, x_write, x_resp_ready;
  logic [63:0] x_addr, x_wdata;
  logic        x1_ready, x1_valid, x1_err, x4_ready, x4_valid, x4_err;
  logic [63:0] x1_rdata, x4_rdata;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(x_valid), .req_ready(x1_ready), .req_write(x_write),
    .req_addr(x_addr), .req_wdata(x_wdata),
    .resp_valid(x1_valid), .resp_ready(x_resp_ready),
    .resp_rdata(x1_rdata), .resp_err(x1_err)
  );

  dmem_responder #(.N(N), .DEPTH(DEPTH), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(x_valid), .req_ready(x4_ready), .req_write(x_write),
    .req_addr(x_addr), .req_wdata(x_wdata),
    .resp_valid(x4_valid), .resp_ready(x_resp_ready),
    .resp_rdata(x4_rdata), .resp_err(x4_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic void add(input logic w, input logic [63:0] a, input logic [63:0] d,
                              input logic [63:0] r, input logic e);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.rdata = r; v.err = e;
    vecs.push_back(v);
  endfunction

  // Scoreboard: every completed response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got rdata 0x%h, expected no response", resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, mon_e.rdata);
        checkOutput("resp_err", {63'b0, resp_err}, {63'b0, mon_e.err});
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) timeoutFail("req_ready");
  endtask

  task automatic applyStimulus(input logic write, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic err,
                               input bit push, input bit check_lat);
    int   n;
    logic busy_ready;
    exp_t e;
    waitReady();
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      e.rdata = rdata;
      e.err   = err;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 64'($urandom);
    req_wdata = {$urandom, $urandom};
    if (check_lat) begin
      n = 0;
      busy_ready = 1'b0;
      do begin
        @(negedge clk);
        n++;
        if (req_ready) busy_ready = 1'b1;
      end while (!resp_valid && n < 20);
      checkOutput("latency", 64'(n), 64'(LAT));
      checkOutput("busy_ready", {63'b0, busy_ready}, 64'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      timeoutFail("drain");
      sb.delete();
    end
    @(posedge clk); #1;
    checkOutput("idle_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("idle_rdata", resp_rdata, 64'd0);
    checkOutput("idle_ready", {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs, acc, c, l1, l4, n;
    logic [63:0] d1, d4;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    x_valid = 1'b0; x_write = 1'b0; x_addr = '0; x_wdata = '0; x_resp_ready = 1'b1;

    #2;
    checkOutput("rst_req_ready", {63'b0, req_ready}, 64'd0);
    checkOutput("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
    checkOutput("rst_resp_err", {63'b0, resp_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("ready_before_clk", {63'b0, req_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_clk", {63'b0, req_ready}, 64'd1);

    add(1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0);
    add(1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    add(1'b1, 64'h00,  64'h1, 64'h0, 1'b0);
    add(1'b1, 64'h08,  64'h2, 64'h0, 1'b0);
    add(1'b1, 64'h30,  64'h3030, 64'h0, 1'b0);
    add(1'b0, 64'h00,  64'h0, 64'h1, 1'b0);
    add(1'b0, 64'h08,  64'h0, 64'h2, 1'b0);
    add(1'b1, 64'h1F8, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b0);
    add(1'b0, 64'h1F8, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 1'b0);
    add(1'b1, 64'h10,  64'h1234, 64'h0, 1'b0);
    add(1'b0, 64'h10,  64'h0, 64'h1234, 1'b0);
`ifdef DMEM_ERR_EN
    add(1'b1, 64'h0C,  64'hBAD, 64'h0, 1'b1);
    add(1'b1, 64'h200, 64'hBAD, 64'h0, 1'b1);
    add(1'b0, 64'h08,  64'h0, 64'h2, 1'b0);
    add(1'b0, 64'h0C,  64'h0, 64'h0, 1'b1);
    add(1'b0, 64'h200, 64'h0, 64'h0, 1'b1);
    add(1'b0, 64'h1F8, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 1'b0);
`else
    add(1'b1, 64'h208, 64'h77, 64'h0, 1'b0);
    add(1'b0, 64'h08,  64'h0, 64'h77, 1'b0);
    add(1'b0, 64'h0D,  64'h0, 64'h77, 1'b0);
    add(1'b1, 64'h08,  64'h2, 64'h0, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b1, 1'b1);
      drain();
    end

    // Backpressure, with a competing store request that must not be accepted.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 64'h10, 64'h0, 64'h1234, 1'b0, 1'b1, 1'b1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h30; req_wdata = '1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", {63'b0, resp_valid}, 64'd1);
      checkOutput("bp_rdata", resp_rdata, 64'h1234);
      checkOutput("bp_req_ready", {63'b0, req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_release_ready", {63'b0, req_ready}, 64'd1);
    drain();
    applyStimulus(1'b0, 64'h30, 64'h0, 64'h3030, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back loads with req_valid held high.
    waitReady();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h00;
    sb.push_back('{64'h1, 1'b0});
    @(posedge clk); #1;
    req_addr = 64'h08;
    sb.push_back('{64'h2, 1'b0});
    hs = -1; acc = -1; c = 0;
    while (acc < 0 && c < 30) begin
      @(negedge clk);
      c++;
      if (resp_valid && resp_ready) hs = c;
      if (req_valid && req_ready) acc = c;
    end
    checkOutput("b2b_gap", 64'(acc - hs), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Reset in the middle of a store; the store was already committed.
    applyStimulus(1'b1, 64'h18, 64'h55, 64'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", {63'b0, resp_valid}, 64'd0);
    checkOutput("midrst_ready", {63'b0, req_ready}, 64'd0);
    checkOutput("midrst_rdata", resp_rdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(1'b0, 64'h18, 64'h0, 64'h55, 1'b0, 1'b1, 1'b1);
    drain();

    // LATENCY=1 and LATENCY=4 instances: store then load the same word.
    for (int w = 1; w >= 0; w--) begin
      n = 0;
      while (!(x1_ready && x4_ready) && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      x_valid = 1'b1; x_write = (w == 1); x_addr = 64'h20; x_wdata = 64'h5A;
      @(posedge clk); #1;
      x_valid = 1'b0; x_wdata = 64'h0;
      l1 = 0; l4 = 0; d1 = '0; d4 = '0;
      for (int k = 1; k <= 20 && (l1 == 0 || l4 == 0); k++) begin
        @(negedge clk);
        if (x1_valid && l1 == 0) begin l1 = k; d1 = x1_rdata; end
        if (x4_valid && l4 == 0) begin l4 = k; d4 = x4_rdata; end
      end
      checkOutput("lat1", 64'(l1), 64'd1);
      checkOutput("lat4", 64'(l4), 64'd4);
      checkOutput("lat1_rdata", d1, (w == 1) ? 64'h0 : 64'h5A);
      checkOutput("lat4_rdata", d4, (w == 1) ? 64'h0 : 64'h5A);
      checkOutput("lat_err", {62'b0, x1_err, x4_err}, 64'd0);
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
